// File: rtl/kgp_adder_if.sv
// kgp_adder_if: valid/ready operand and result bus for kgp_adder_pipe
interface kgp_adder_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/kgp_adder_pipe.sv
// kgp_adder_pipe: 3-stage Kogge-Stone add/sub with valid/ready; KGP_ADDER_SAT_EN enables signed saturation
module kgp_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  kgp_adder_if.slave bus
);
  logic             en;
  logic             v1, v2, v3;
  logic [WIDTH-1:0] a1, b1;
  logic             c01;
  logic [WIDTH:0]   c2;
  logic [WIDTH-1:0] p2;
  logic [WIDTH-1:0] sum3;
  logic             cout3, ovf3;
  logic [WIDTH:0]   gv, pv, ng, np;
  logic [WIDTH-1:0] raw, sum_n;
  logic             ovf_n;
  assign en            = bus.out_ready | ~v3;
  assign bus.in_ready  = en;
  assign bus.out_valid = v3;
  assign bus.out_sum   = sum3;
  assign bus.out_cout  = cout3;
  assign bus.out_ovf   = ovf3;
  // node 0 is the carry-in (G or K, never P); node k holds the carry into bit k
  always_comb begin
    gv = {a1 & b1, c01};
    pv = {a1 ^ b1, 1'b0};
    ng = '0;
    np = '0;
    for (int s = 1; s <= WIDTH; s = s * 2) begin
      ng = gv;
      np = pv;
      for (int k = s; k <= WIDTH; k++) begin
        ng[k] = gv[k] | (pv[k] & gv[k-s]);
        np[k] = pv[k] & pv[k-s];
      end
      gv = ng;
      pv = np;
    end
  end
  assign raw   = p2 ^ c2[WIDTH-1:0];
  assign ovf_n = c2[WIDTH] ^ c2[WIDTH-1];
`ifdef KGP_ADDER_SAT_EN
  assign sum_n = ovf_n ? {~raw[WIDTH-1], {(WIDTH-1){raw[WIDTH-1]}}} : raw;
`else
  assign sum_n = raw;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      c01   <= 1'b0;
      c2    <= '0;
      p2    <= '0;
      sum3  <= '0;
      cout3 <= 1'b0;
      ovf3  <= 1'b0;
    end else if (en) begin
      v1    <= bus.in_valid;
      a1    <= bus.in_a;
      b1    <= bus.in_sub ? ~bus.in_b : bus.in_b;
      c01   <= bus.in_sub | bus.in_cin;
      v2    <= v1;
      c2    <= gv;
      p2    <= a1 ^ b1;
      v3    <= v2;
      sum3  <= sum_n;
      cout3 <= c2[WIDTH];
      ovf3  <= ovf_n;
    end
  end
endmodule
